// File: rtl/com_uart_if.sv
// CPU communications-port bus between the CPU (master) and com_uart (slave).
interface com_uart_if;
    logic [7:0] com_addr;
    logic [7:0] com_wr;
    logic       com_wr_en;
    logic       com_rd_en;
    logic [7:0] com_rd;

    modport master (output com_addr, output com_wr, output com_wr_en, output com_rd_en, input com_rd);
    modport slave  (input com_addr, input com_wr, input com_wr_en, input com_rd_en, output com_rd);
endinterface

// File: rtl/com_uart.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs behind the CPU COM port.
// Optional CTRL register and internal loopback: define COM_LOOPBACK_EN.
module com_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    com_uart_if.slave  bus,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic       irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] A_DATA   = 8'h01;
    localparam logic [7:0] A_STATUS = 8'h02;
    localparam logic [7:0] A_CLEAR  = 8'h03;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [AW:0]   tx_wptr_q, tx_rptr_q;
    logic          tx_full_s, tx_empty_s, tx_push_s, tx_pop_s, tx_end_s;
    logic [7:0]    tx_head_s;
    state_t        tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;
    logic          tx_line_q;

    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW:0]   rx_wptr_q, rx_rptr_q, rx_wptr_d, rx_rptr_d;
    logic          rx_full_s, rx_empty_s, rx_pop_s, rx_push_s, rx_write_s, rx_done_s;
    logic          rx_in_s, rx_meta_q, rx_sync_q, rx_prev_q;
    state_t        rx_state_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;

    logic          overrun_q, frame_err_q, irq_q;
    logic          overrun_set_s, frame_set_s, clr_wr_s;
    logic [7:0]    rd_s;

    assign tx_empty_s = (tx_wptr_q == tx_rptr_q);
    assign tx_full_s  = (tx_wptr_q[AW] != tx_rptr_q[AW]) && (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign tx_head_s  = tx_mem_q[tx_rptr_q[AW-1:0]];
    assign tx_push_s  = bus.com_wr_en && (bus.com_addr == A_DATA) && !tx_full_s;
    assign tx_end_s   = (tx_cnt_q == CNT_MAX);
    // The FSM may refill from STOP so consecutive frames are gapless.
    assign tx_pop_s   = !tx_empty_s && ((tx_state_q == S_IDLE) || ((tx_state_q == S_STOP) && tx_end_s));

    assign rx_empty_s = (rx_wptr_q == rx_rptr_q);
    assign rx_full_s  = (rx_wptr_q[AW] != rx_rptr_q[AW]) && (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
    assign rx_pop_s   = bus.com_rd_en && (bus.com_addr == A_DATA) && !rx_empty_s;
    assign rx_done_s  = (rx_state_q == S_STOP) && (rx_cnt_q == CNT_MAX);
    assign rx_push_s  = rx_done_s && rx_sync_q;
    assign frame_set_s = rx_done_s && !rx_sync_q;
    assign rx_write_s  = rx_push_s && (!rx_full_s || rx_pop_s);
    assign overrun_set_s = rx_push_s && rx_full_s && !rx_pop_s;
    assign clr_wr_s    = bus.com_wr_en && (bus.com_addr == A_CLEAR);

`ifdef COM_LOOPBACK_EN
    logic loopback_q;

    // CTRL register: loopback enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            loopback_q <= 1'b0;
        end else if (bus.com_wr_en && (bus.com_addr == 8'h04)) begin
            loopback_q <= bus.com_wr[0];
        end else begin
            loopback_q <= loopback_q;
        end
    end

    assign rx_in_s = loopback_q ? tx_line_q : uart_rx;
    assign uart_tx = tx_line_q | loopback_q;
`else
    assign rx_in_s = uart_rx;
    assign uart_tx = tx_line_q;
`endif
    assign irq = irq_q;

    // TX FIFO storage and pointers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wptr_q <= {(AW+1){1'b0}};
            tx_rptr_q <= {(AW+1){1'b0}};
        end else begin
            if (tx_push_s) begin
                tx_mem_q[tx_wptr_q[AW-1:0]] <= bus.com_wr;
            end
            tx_wptr_q <= tx_wptr_q + {{AW{1'b0}}, tx_push_s};
            tx_rptr_q <= tx_rptr_q + {{AW{1'b0}}, tx_pop_s};
        end
    end

    // TX serialiser: start, 8 data bits LSB first, stop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= {CW{1'b0}};
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_line_q  <= 1'b1;
        end else begin
            case (tx_state_q)
                S_IDLE: begin
                    if (tx_pop_s) begin
                        tx_shift_q <= tx_head_s;
                        tx_line_q  <= 1'b0;
                        tx_cnt_q   <= {CW{1'b0}};
                        tx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tx_end_s) begin
                        tx_cnt_q   <= {CW{1'b0}};
                        tx_line_q  <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_bit_q   <= 3'd0;
                        tx_state_q <= S_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_DATA: begin
                    if (tx_end_s) begin
                        tx_cnt_q <= {CW{1'b0}};
                        if (tx_bit_q == 3'd7) begin
                            tx_line_q  <= 1'b1;
                            tx_state_q <= S_STOP;
                        end else begin
                            tx_line_q  <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_STOP: begin
                    if (tx_end_s) begin
                        tx_cnt_q <= {CW{1'b0}};
                        if (tx_pop_s) begin
                            tx_shift_q <= tx_head_s;
                            tx_line_q  <= 1'b0;
                            tx_state_q <= S_START;
                        end else begin
                            tx_state_q <= S_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    tx_state_q <= S_IDLE;
                    tx_line_q  <= 1'b1;
                end
            endcase
        end
    end

    // Two-stage synchroniser plus edge history for start detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in_s;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX deserialiser: mid-bit sampling, false-start rejection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= {CW{1'b0}};
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
        end else begin
            case (rx_state_q)
                S_IDLE: begin
                    rx_cnt_q <= {CW{1'b0}};
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == CNT_HALF) begin
                        rx_cnt_q   <= {CW{1'b0}};
                        rx_bit_q   <= 3'd0;
                        rx_state_q <= rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_DATA: begin
                    if (rx_cnt_q == CNT_MAX) begin
                        rx_cnt_q   <= {CW{1'b0}};
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= S_STOP;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_STOP: begin
                    if (rx_done_s) begin
                        rx_cnt_q   <= {CW{1'b0}};
                        rx_state_q <= S_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    // Next RX pointers; a same-cycle pop frees the slot the push then uses.
    always_comb begin
        rx_wptr_d = rx_wptr_q + {{AW{1'b0}}, rx_write_s};
        rx_rptr_d = rx_rptr_q + {{AW{1'b0}}, rx_pop_s};
    end

    // RX FIFO storage, pointers and interrupt.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_wptr_q <= {(AW+1){1'b0}};
            rx_rptr_q <= {(AW+1){1'b0}};
            irq_q     <= 1'b0;
        end else begin
            if (rx_write_s) begin
                rx_mem_q[rx_wptr_q[AW-1:0]] <= rx_shift_q;
            end
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            irq_q     <= (rx_wptr_d != rx_rptr_d);
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_set_s | (overrun_q & ~(clr_wr_s & bus.com_wr[4]));
            frame_err_q <= frame_set_s | (frame_err_q & ~(clr_wr_s & bus.com_wr[5]));
        end
    end

    // Read-data decode.
    always_comb begin
        rd_s = 8'h00;
        case (bus.com_addr)
            A_DATA:   rd_s = rx_empty_s ? 8'h00 : rx_mem_q[rx_rptr_q[AW-1:0]];
            A_STATUS: rd_s = {1'b0, (tx_state_q != S_IDLE), frame_err_q, overrun_q,
                              rx_full_s, rx_empty_s, tx_empty_s, tx_full_s};
`ifdef COM_LOOPBACK_EN
            8'h04:    rd_s = {7'd0, loopback_q};
`endif
            default:  rd_s = 8'h00;
        endcase
    end

    assign bus.com_rd = rd_s;
endmodule

// File: tb/tb_com_uart.sv
// Randomised scoreboard bench for com_uart: a queue-based reference model
// predicts line frames and register reads; monitors compare as they appear.
module tb_com_uart;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    typedef struct { logic [7:0] val; string tag; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx, irq;
    com_uart_if bus();

    com_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus), .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    logic [7:0] tx_exp_q[$];
    exp_t       rd_exp_q[$];
    int         tx_starts[$];
    logic [7:0] rx_model[$];
    bit m_ov = 1'b0, m_fe = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] exp_status(input bit txf, input bit txe, input bit busy);
        return {1'b0, busy, m_fe, m_ov, (rx_model.size() == DEPTH), (rx_model.size() == 0), txe, txf};
    endfunction

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Line monitor: decodes each frame on uart_tx and compares with the scoreboard.
    initial begin : tx_monitor
        logic [7:0] b;
        logic start_b, stop_b;
        bit aborted;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0 && rst === 1'b1) begin
                tx_starts.push_back(cycle);
                aborted = 1'b0;
                repeat (CPB/2) begin @(negedge clk); if (!rst) aborted = 1'b1; end
                start_b = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(negedge clk); if (!rst) aborted = 1'b1; end
                    b[i] = uart_tx;
                end
                repeat (CPB) begin @(negedge clk); if (!rst) aborted = 1'b1; end
                stop_b = uart_tx;
                if (!aborted) begin
                    check("tx_frame_expected", (tx_exp_q.size() != 0), 1);
                    if (tx_exp_q.size() != 0) begin
                        check("tx_byte", {start_b, b, stop_b}, {1'b0, tx_exp_q.pop_front(), 1'b1});
                    end
                end
            end
        end
    end

    // Read monitor: every read strobe consumes one expected value.
    initial begin : rd_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.com_rd_en === 1'b1) begin
                if (rd_exp_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    e = rd_exp_q.pop_front();
                    check(e.tag, bus.com_rd, e.val);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        bus.com_addr = a; bus.com_wr = d; bus.com_wr_en = 1'b1;
        @(posedge clk); #1;
        bus.com_addr = 8'h00; bus.com_wr = 8'h00; bus.com_wr_en = 1'b0;
    endtask

    task automatic cpu_rd(input logic [7:0] a, input logic [7:0] e, input string tag);
        rd_exp_q.push_back('{e, tag});
        bus.com_addr = a; bus.com_rd_en = 1'b1;
        @(posedge clk); #1;
        bus.com_addr = 8'h00; bus.com_rd_en = 1'b0;
    endtask

    task automatic rd_data(input string tag);
        logic [7:0] e;
        e = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
        cpu_rd(8'h01, e, tag);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0; cyc(CPB);
        for (int i = 0; i < 8; i++) begin uart_rx = b[i]; cyc(CPB); end
        uart_rx = stop; cyc(CPB);
        uart_rx = 1'b1; cyc(4);
        if (!stop) m_fe = 1'b1;
        else if (rx_model.size() == DEPTH) m_ov = 1'b1;
        else rx_model.push_back(b);
    endtask

    task automatic wait_tx_drain();
        for (int i = 0; i < 12*CPB*(DEPTH+2) && tx_exp_q.size() != 0; i++) cyc(1);
        check("tx_drain", tx_exp_q.size(), 0);
        cyc(CPB);
    endtask

    initial begin : stim
        logic [7:0] b;
        int occ, n0, n;
        bit st;
        bus.com_addr = 8'h00; bus.com_wr = 8'h00; bus.com_wr_en = 1'b0; bus.com_rd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_uart_tx", uart_tx, 1);
        check("reset_irq", irq, 0);
        rst = 1'b1;
        cpu_rd(8'h02, 8'h06, "reset_status");
        cpu_rd(8'h05, 8'h00, "unmapped_05");
        cpu_rd(8'h03, 8'h00, "clear_reads_0");
        cpu_rd(8'hFF, 8'h00, "unmapped_ff");
        cpu_rd(8'h01, 8'h00, "rx_empty_read");

        // Single frame with start-bit latency.
        tx_exp_q.push_back(8'hA5);
        cpu_wr(8'h01, 8'hA5);
        check("tx_idle_at_write_edge", uart_tx, 1);
        cyc(1);
        check("tx_start_next_edge", uart_tx, 0);
        cyc(2*CPB);
        cpu_rd(8'h02, exp_status(1'b0, 1'b1, 1'b1), "status_busy");
        wait_tx_drain();
        cpu_rd(8'h02, exp_status(1'b0, 1'b1, 1'b0), "status_after_frame");

        // Ignored writes to read-only and unmapped registers.
        cpu_wr(8'h02, 8'hFF);
        cpu_wr(8'h07, 8'hFF);
        cpu_wr(8'h04, 8'hFF);
        cpu_rd(8'h04, 8'h00, "ctrl_read");
        cpu_rd(8'h02, exp_status(1'b0, 1'b1, 1'b0), "status_ignored_wr");

        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            tx_exp_q.push_back(b);
            cpu_wr(8'h01, b);
            wait_tx_drain();
        end

        // Burst: the FSM drains the first byte a cycle after it lands.
        n0 = tx_starts.size();
        occ = 0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            b = 8'h10 + 8'(k);
            if (occ < DEPTH) begin
                occ++;
                tx_exp_q.push_back(b);
            end
            cpu_wr(8'h01, b);
            if (k == 0) occ--;
        end
        cpu_rd(8'h02, exp_status(occ == DEPTH, 1'b0, 1'b1), "status_tx_full");
        wait_tx_drain();
        check("burst_frames", tx_starts.size() - n0, DEPTH + 1);
        for (int k = n0 + 1; k < tx_starts.size(); k++)
            check("burst_no_gap", tx_starts[k] - tx_starts[k-1], 10*CPB);

        // Directed receive.
        send_rx(8'h3C, 1'b1);
        check("irq_after_frame", irq, 1);
        send_rx(8'hFF, 1'b1);
        rd_data("rx_data_0");
        rd_data("rx_data_1");
        rd_data("rx_data_empty");
        cpu_rd(8'h02, exp_status(1'b0, 1'b1, 1'b0), "status_rx_drained");
        cyc(1);
        check("irq_after_drain", irq, 0);

        // Overrun, then clear.
        for (int k = 0; k < DEPTH + 1; k++) send_rx(8'($urandom), 1'b1);
        cpu_rd(8'h02, exp_status(1'b0, 1'b1, 1'b0), "status_overrun");
        cpu_wr(8'h03, 8'h10);
        m_ov = 1'b0;
        cpu_rd(8'h02, exp_status(1'b0, 1'b1, 1'b0), "status_ov_cleared");
        repeat (DEPTH + 1) rd_data("rx_data_ov");

        // Framing error and glitch.
        send_rx(8'h81, 1'b0);
        cpu_rd(8'h02, exp_status(1'b0, 1'b1, 1'b0), "status_frame_err");
        cpu_wr(8'h03, 8'h20);
        m_fe = 1'b0;
        uart_rx = 1'b0; cyc(1); uart_rx = 1'b1; cyc(3*CPB);
        cpu_rd(8'h02, exp_status(1'b0, 1'b1, 1'b0), "status_glitch");
        check("irq_glitch", irq, 0);

        // Randomised receive rounds.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, DEPTH + 2);
            for (int k = 0; k < n; k++) begin
                st = ($urandom_range(0, 5) != 0);
                send_rx(8'($urandom), st);
            end
            check("irq_rand", irq, (rx_model.size() != 0));
            cpu_rd(8'h02, exp_status(1'b0, 1'b1, 1'b0), "status_rand");
            b = {2'b00, 1'($urandom), 1'($urandom), 4'($urandom)};
            cpu_wr(8'h03, b);
            if (b[4]) m_ov = 1'b0;
            if (b[5]) m_fe = 1'b0;
            cpu_rd(8'h02, exp_status(1'b0, 1'b1, 1'b0), "status_rand_clr");
            repeat (rx_model.size() + 1) rd_data("rx_data_rand");
        end

        // Reset mid-frame aborts transmission.
        tx_exp_q.push_back(8'h00);
        cpu_wr(8'h01, 8'h00);
        cyc(3*CPB);
        rst = 1'b0;
        cyc(1);
        check("reset_mid_tx_line", uart_tx, 1);
        rst = 1'b1;
        tx_exp_q.delete();
        rx_model.delete();
        m_ov = 1'b0; m_fe = 1'b0;
        cyc(10*CPB);
        cpu_rd(8'h02, 8'h06, "status_after_reset");

`ifdef COM_LOOPBACK_EN
        cpu_wr(8'h04, 8'h01);
        cpu_rd(8'h04, 8'h01, "ctrl_loopback");
        cpu_wr(8'h01, 8'h5A);
        st = 1'b1;
        for (int i = 0; i < 12*CPB; i++) begin
            if (uart_tx !== 1'b1) st = 1'b0;
            cyc(1);
        end
        check("loopback_tx_held", st, 1);
        rx_model.push_back(8'h5A);
        rd_data("loopback_data");
        cpu_wr(8'h04, 8'h00);
`endif

        cyc(4);
        check("rd_queue_empty", rd_exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
